hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Parametrised hazard controller for the in-order RISC-V pipeline (F/D/E/M/W).
- Generates per-source forwarding selects for the E stage.
- Detects load-use hazards and inserts LD_LAT bubbles through a counter-driven FSM.
- Flushes the wrong path on a taken branch resolved in E.
- Freezes the whole pipeline while data memory is busy.

Parameters:
REG_ADDR_W, 5, register address width (x0 = all zeros).
NUM_SRC, 2, source operands per instruction (2 or 3).
LD_LAT, 1, bubble cycles between a load in E and a dependent instruction entering E (1..7).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
rs_D  in  NUM_SRC*REG_ADDR_W  source regs in D (src i at slice i).
rs_E  in  NUM_SRC*REG_ADDR_W  source regs in E.
rd_E  in  REG_ADDR_W  destination reg in E.
reg_wr_E  in  1  E instruction writes rd_E.
is_load_E  in  1  E instruction is a load.
rd_M  in  REG_ADDR_W  destination reg in M.
reg_wr_M  in  1  M instruction writes rd_M.
rd_W  in  REG_ADDR_W  destination reg in W.
reg_wr_W  in  1  W instruction writes rd_W.
branch_taken_E  in  1  taken branch or jump resolved in E.
mem_busy  in  1  data memory not ready; M cannot retire.
fwd_sel_E  out  NUM_SRC*2  per-source select: 0 = regfile, 1 = from W, 2 = from M.
stall_F, stall_D, stall_E, stall_M  out  1 each  hold the stage register.
flush_D, flush_E  out  1 each  load a bubble into the stage register.

Behaviour:
- Forwarding (combinational, per source i):
  - Select 2 if rs_E[i]==rd_M and reg_wr_M and rs_E[i]!=0.
  - Otherwise select 1 if rs_E[i]==rd_W and reg_wr_W and rs_E[i]!=0.
  - Otherwise select 0. M has priority over W.
  - Forwarding is independent of FSM state and stalls.
- Load-use detect (lu_hit):
  - Asserted when is_load_E and reg_wr_E and rd_E!=0 and rd_E equals any rs_D[i].
  - All NUM_SRC slices are compared.
- FSM states: RUN, LU_STALL, MEM_WAIT. Registers: state and 3-bit cnt, plus ret_state (RUN or LU_STALL) for MEM_WAIT.
- Priority, highest first:
  1. mem_busy:
     - stall_F/D/E/M = 1; flush_D/E = 0.
     - Enter MEM_WAIT and save the prior state in ret_state. cnt is frozen.
     - Leave MEM_WAIT on the first cycle mem_busy=0, returning to ret_state with cnt unchanged.
  2. branch_taken_E:
     - flush_D = flush_E = 1; all stalls 0.
     - Next state RUN, cnt = 0. Any pending load-use stall is cancelled.
  3. RUN with lu_hit:
     - stall_F = stall_D = 1, flush_E = 1.
     - If LD_LAT > 1, load cnt = LD_LAT-1 and go to LU_STALL; otherwise stay in RUN.
  4. LU_STALL:
     - stall_F = stall_D = 1, flush_E = 1, cnt decrements.
     - Go to RUN in the cycle cnt reaches 1, i.e. LU_STALL lasts exactly LD_LAT-1 cycles.
  5. Otherwise: all stall and flush outputs 0.
- Reset:
  - state = RUN, cnt = 0, ret_state = RUN. All stall/flush outputs 0.
  - Reset asserted mid-stall aborts the stall immediately (asynchronous).
- Outputs are combinational from state, cnt and inputs; there is no added latency.
- Simultaneous events:
  - mem_busy overrides a branch. The branch is held in E and its flush fires on the first non-busy cycle.
  - A branch with lu_hit in the same cycle: the flush wins.

Optional Feature:
HAZ_PERF_CNT_EN: adds two output ports, both cleared by reset and saturating at all-ones.
- stall_cycles[31:0] increments every cycle stall_D=1.
- flush_events[31:0] increments every cycle flush_D=1.
Without the macro, the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum {FWD_NONE=2'd0, FWD_W=2'd1, FWD_M=2'd2}.
  - haz_state_t enum {RUN, LU_STALL, MEM_WAIT}.
  - Constant LD_LAT_MAX=7.
- Sub-module fwd_select: combinational, one source compare producing fwd_sel_t. Instantiated NUM_SRC times by generate.

Test Plan:
1. Forwarding priority: rs_E = {x5, x5}, rd_M = x5 with reg_wr_M = 1, rd_W = x5 with reg_wr_W = 1 -> fwd_sel_E = {2,2}. Then reg_wr_M = 0 -> {1,1}. Then rs_E = x0 -> 0.
2. Load-use, LD_LAT=1 versus LD_LAT=3: load to x7 in E, rs_D[1] = x7.
   - LD_LAT=1 -> stall_F/D and flush_E high for exactly 1 cycle, then RUN.
   - LD_LAT=3 -> high for 3 consecutive cycles.
   - rd_E = x0 -> no stall.
3. Branch cancels stall: LD_LAT=3 load-use begins, then branch_taken_E in cycle 2 -> flush_D = flush_E = 1, stalls 0, RUN next cycle.
4. Memory wait: mem_busy held 4 cycles during LU_STALL with cnt=2 -> all four stalls high, no flush. After release, 2 more LU_STALL cycles, then RUN.
5. Reset mid-operation: rst_n low during LU_STALL -> outputs 0 asynchronously; with rst_n high, no stall until a fresh lu_hit.
6. Perf counters (HAZ_PERF_CNT_EN): scenario 2 with LD_LAT=3 plus one branch -> stall_cycles = 3, flush_events = 1.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Longest load-to-use bubble sequence the stall counter can express.
  localparam int LD_LAT_MAX = 7;

  // E-stage operand source: register file, W-stage result or M-stage result.
  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_W    = 2'd1,
    FWD_M    = 2'd2
  } fwd_sel_t;

  // Controller state: normal flow, load-use bubble insertion, memory freeze.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } haz_state_t;

endpackage

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Forwarding select for a single E-stage source operand.
// x0 never forwards; a match in M beats a match in W because M is younger.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_wr_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_wr_w,
  output fwd_sel_t              sel
);

  // Pick the youngest in-flight producer of this source register.
  always_comb begin
    sel = FWD_NONE;
    if (rs != '0) begin
      if (reg_wr_m && (rs == rd_m)) begin
        sel = FWD_M;
      end else if (reg_wr_w && (rs == rd_w)) begin
        sel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the in-order F/D/E/M/W pipeline: E-stage forwarding,
// load-use bubble insertion, branch flush and data-memory freeze.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int LD_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_D,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_E,
  input  logic [REG_ADDR_W-1:0]         rd_E,
  input  logic                          reg_wr_E,
  input  logic                          is_load_E,
  input  logic [REG_ADDR_W-1:0]         rd_M,
  input  logic                          reg_wr_M,
  input  logic [REG_ADDR_W-1:0]         rd_W,
  input  logic                          reg_wr_W,
  input  logic                          branch_taken_E,
  input  logic                          mem_busy,
  output logic [NUM_SRC*2-1:0]          fwd_sel_E,
  output logic                          stall_F,
  output logic                          stall_D,
  output logic                          stall_E,
  output logic                          stall_M,
  output logic                          flush_D,
  output logic                          flush_E
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   flush_events
`endif
);

  // Counter value loaded on the first bubble; the RUN cycle itself is bubble one.
  localparam int          LdLatClamped = (LD_LAT > LD_LAT_MAX) ? LD_LAT_MAX : LD_LAT;
  localparam logic [2:0]  LuReload     = 3'(LdLatClamped - 1);

  haz_state_t state_q, state_d;
  haz_state_t ret_state_q, ret_state_d;
  haz_state_t eff_state;
  logic [2:0] cnt_q, cnt_d;
  logic       lu_hit;
  logic       stall_f_int, stall_d_int, stall_e_int, stall_m_int;
  logic       flush_d_int, flush_e_int;

  // One forwarding comparator per source operand slice.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_sel_t sel;
    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_select (
      .rs       (rs_E[i*REG_ADDR_W +: REG_ADDR_W]),
      .rd_m     (rd_M),
      .reg_wr_m (reg_wr_M),
      .rd_w     (rd_W),
      .reg_wr_w (reg_wr_W),
      .sel      (sel)
    );
    assign fwd_sel_E[2*i +: 2] = sel;
  end

  // A load in E whose destination is read by any D-stage source.
  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_D[i*REG_ADDR_W +: REG_ADDR_W] == rd_E) begin
        lu_hit = 1'b1;
      end
    end
    lu_hit = lu_hit && is_load_E && reg_wr_E && (rd_E != '0);
  end

  // Next-state and stall/flush decode; memory freeze beats branch beats load-use.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ret_state_d = ret_state_q;
    stall_f_int = 1'b0;
    stall_d_int = 1'b0;
    stall_e_int = 1'b0;
    stall_m_int = 1'b0;
    flush_d_int = 1'b0;
    flush_e_int = 1'b0;
    eff_state   = (state_q == MEM_WAIT) ? ret_state_q : state_q;

    if (mem_busy) begin
      stall_f_int = 1'b1;
      stall_d_int = 1'b1;
      stall_e_int = 1'b1;
      stall_m_int = 1'b1;
      state_d     = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        ret_state_d = state_q;
      end
    end else if (branch_taken_E) begin
      flush_d_int = 1'b1;
      flush_e_int = 1'b1;
      state_d     = RUN;
      cnt_d       = 3'd0;
      ret_state_d = RUN;
    end else begin
      ret_state_d = RUN;
      case (eff_state)
        LU_STALL: begin
          stall_f_int = 1'b1;
          stall_d_int = 1'b1;
          flush_e_int = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            state_d = LU_STALL;
            cnt_d   = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = RUN;
          if (lu_hit) begin
            stall_f_int = 1'b1;
            stall_d_int = 1'b1;
            flush_e_int = 1'b1;
            if (LdLatClamped > 1) begin
              state_d = LU_STALL;
              cnt_d   = LuReload;
            end
          end
        end
      endcase
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ret_state_q <= RUN;
      cnt_q       <= 3'd0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      cnt_q       <= cnt_d;
    end
  end

  // Reset silences every pipeline control immediately, not just at the next edge.
  assign stall_F = rst_n & stall_f_int;
  assign stall_D = rst_n & stall_d_int;
  assign stall_E = rst_n & stall_e_int;
  assign stall_M = rst_n & stall_m_int;
  assign flush_D = rst_n & flush_d_int;
  assign flush_E = rst_n & flush_e_int;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  // Saturating event counters for stalled-decode and flushed-decode cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (stall_d_int && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (flush_d_int && (flush_events_q != '1)) begin
      flush_events_d = flush_events_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: one instance with LD_LAT=3 (suffix _a)
// and one with LD_LAT=1 (suffix _b) share the same stimulus.
// Control outputs are compared as {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E}.
module tb_hazard_ctrl_unit;

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] LUS  = 6'b110001;
  localparam logic [5:0] MEMW = 6'b111100;
  localparam logic [5:0] BRF  = 6'b000011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rs_D, rs_E;
  logic [4:0] rd_E, rd_M, rd_W;
  logic       reg_wr_E, is_load_E, reg_wr_M, reg_wr_W, branch_taken_E, mem_busy;

  logic [3:0] fwd_a, fwd_b;
  logic       sf_a, sd_a, se_a, sm_a, fd_a, fe_a;
  logic       sf_b, sd_b, se_b, sm_b, fd_b, fe_b;
  logic [5:0] haz_a, haz_b;

  int checks = 0;
  int errors = 0;

  assign haz_a = {sf_a, sd_a, se_a, sm_a, fd_a, fe_a};
  assign haz_b = {sf_b, sd_b, se_b, sm_b, fd_b, fe_b};

  always #5 clk = ~clk;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] sc_a, fv_a, sc_b, fv_b;
`endif

  hazard_ctrl_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LD_LAT(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rs_D(rs_D), .rs_E(rs_E), .rd_E(rd_E),
    .reg_wr_E(reg_wr_E), .is_load_E(is_load_E), .rd_M(rd_M), .reg_wr_M(reg_wr_M),
    .rd_W(rd_W), .reg_wr_W(reg_wr_W), .branch_taken_E(branch_taken_E),
    .mem_busy(mem_busy), .fwd_sel_E(fwd_a), .stall_F(sf_a), .stall_D(sd_a),
    .stall_E(se_a), .stall_M(sm_a), .flush_D(fd_a), .flush_E(fe_a)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(sc_a), .flush_events(fv_a)
`endif
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LD_LAT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rs_D(rs_D), .rs_E(rs_E), .rd_E(rd_E),
    .reg_wr_E(reg_wr_E), .is_load_E(is_load_E), .rd_M(rd_M), .reg_wr_M(reg_wr_M),
    .rd_W(rd_W), .reg_wr_W(reg_wr_W), .branch_taken_E(branch_taken_E),
    .mem_busy(mem_busy), .fwd_sel_E(fwd_b), .stall_F(sf_b), .stall_D(sd_b),
    .stall_E(se_b), .stall_M(sm_b), .flush_D(fd_b), .flush_E(fe_b)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(sc_b), .flush_events(fv_b)
`endif
  );

  // Quiet pipeline: no loads, no writers, no branch, memory ready.
  task automatic set_idle();
    rs_D = '0; rs_E = '0; rd_E = '0; rd_M = '0; rd_W = '0;
    reg_wr_E = 1'b0; is_load_E = 1'b0; reg_wr_M = 1'b0; reg_wr_W = 1'b0;
    branch_taken_E = 1'b0; mem_busy = 1'b0;
  endtask

  // Load to x7 in E with D-stage source 1 reading x7.
  task automatic set_load_use();
    set_idle();
    is_load_E = 1'b1; reg_wr_E = 1'b1; rd_E = 5'd7; rs_D = {5'd7, 5'd2};
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    #2;
    checks++;
    if (haz_a !== IDLE) begin errors++; $display("[TB] FAIL reset_a: got %b expected %b", haz_a, IDLE); end
    checks++;
    if (haz_b !== IDLE) begin errors++; $display("[TB] FAIL reset_b: got %b expected %b", haz_b, IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (haz_a !== IDLE) begin errors++; $display("[TB] FAIL post_reset_a: got %b expected %b", haz_a, IDLE); end
  endtask

  task automatic test_forwarding();
    logic [9:0] rs_v [4];
    logic [3:0] exp_v [4];
    logic       wr_m_v [4];
    rs_v   = '{{5'd5, 5'd5}, {5'd5, 5'd5}, {5'd0, 5'd0}, {5'd3, 5'd5}};
    wr_m_v = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_v  = '{4'b1010, 4'b0101, 4'b0000, 4'b1001};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_idle();
      rs_E = rs_v[k];
      rd_M = (k == 3) ? 5'd3 : 5'd5;
      reg_wr_M = wr_m_v[k];
      rd_W = 5'd5; reg_wr_W = 1'b1;
      if (k == 2) begin rd_M = 5'd0; rd_W = 5'd0; end
      #1;
      checks++;
      if (fwd_a !== exp_v[k]) begin
        errors++;
        $display("[TB] FAIL fwd_vec%0d: got %b expected %b", k, fwd_a, exp_v[k]);
      end
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_load_use();
    logic [5:0] exp_a [4];
    logic [5:0] exp_b [4];
    exp_a = '{LUS, LUS, LUS, IDLE};
    exp_b = '{LUS, IDLE, IDLE, IDLE};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) set_load_use(); else set_idle();
      #1;
      checks++;
      if (haz_a !== exp_a[k]) begin errors++; $display("[TB] FAIL lu_lat3_c%0d: got %b expected %b", k, haz_a, exp_a[k]); end
      checks++;
      if (haz_b !== exp_b[k]) begin errors++; $display("[TB] FAIL lu_lat1_c%0d: got %b expected %b", k, haz_b, exp_b[k]); end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_idle();
      if (k == 0) begin is_load_E = 1'b1; reg_wr_E = 1'b1; rd_E = 5'd0; rs_D = {5'd0, 5'd0}; end
      #1;
      checks++;
      if (haz_a !== IDLE) begin errors++; $display("[TB] FAIL lu_x0_c%0d: got %b expected %b", k, haz_a, IDLE); end
    end
  endtask

  task automatic test_branch_cancel();
    logic [5:0] exp_v [6];
    exp_v = '{LUS, BRF, IDLE, BRF, IDLE, IDLE};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      set_idle();
      if (k == 0) set_load_use();
      if (k == 1) branch_taken_E = 1'b1;
      if (k == 3) begin set_load_use(); branch_taken_E = 1'b1; end
      #1;
      checks++;
      if (haz_a !== exp_v[k]) begin errors++; $display("[TB] FAIL br_a_c%0d: got %b expected %b", k, haz_a, exp_v[k]); end
      checks++;
      if (haz_b !== exp_v[k]) begin errors++; $display("[TB] FAIL br_b_c%0d: got %b expected %b", k, haz_b, exp_v[k]); end
    end
  endtask

  task automatic test_mem_wait();
    logic [5:0] exp_a [11];
    logic [5:0] exp_b [11];
    exp_a = '{LUS, MEMW, MEMW, MEMW, MEMW, LUS, LUS, IDLE, MEMW, BRF, IDLE};
    exp_b = '{LUS, MEMW, MEMW, MEMW, MEMW, IDLE, IDLE, IDLE, MEMW, BRF, IDLE};
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      set_idle();
      if (k == 0) set_load_use();
      if (k >= 1 && k <= 4) mem_busy = 1'b1;
      if (k == 8) begin mem_busy = 1'b1; branch_taken_E = 1'b1; end
      if (k == 9) branch_taken_E = 1'b1;
      #1;
      checks++;
      if (haz_a !== exp_a[k]) begin errors++; $display("[TB] FAIL mem_a_c%0d: got %b expected %b", k, haz_a, exp_a[k]); end
      checks++;
      if (haz_b !== exp_b[k]) begin errors++; $display("[TB] FAIL mem_b_c%0d: got %b expected %b", k, haz_b, exp_b[k]); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_load_use();
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if (haz_a !== LUS) begin errors++; $display("[TB] FAIL rstmid_pre: got %b expected %b", haz_a, LUS); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (haz_a !== IDLE) begin errors++; $display("[TB] FAIL rstmid_async: got %b expected %b", haz_a, IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (haz_a !== IDLE) begin errors++; $display("[TB] FAIL rstmid_idle%0d: got %b expected %b", k, haz_a, IDLE); end
    end
    @(negedge clk);
    set_load_use();
    #1;
    checks++;
    if (haz_a !== LUS) begin errors++; $display("[TB] FAIL rstmid_fresh: got %b expected %b", haz_a, LUS); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_idle();
    end
    #1;
    checks++;
    if (haz_a !== IDLE) begin errors++; $display("[TB] FAIL rstmid_drain: got %b expected %b", haz_a, IDLE); end
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf_counters();
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (sc_a !== 32'd0 || fv_a !== 32'd0) begin
      errors++; $display("[TB] FAIL perf_clear: got %0d/%0d expected 0/0", sc_a, fv_a);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_idle();
      if (k == 0) set_load_use();
      if (k == 3) branch_taken_E = 1'b1;
    end
    #1;
    checks++;
    if (sc_a !== 32'd3) begin errors++; $display("[TB] FAIL perf_stall_a: got %0d expected 3", sc_a); end
    checks++;
    if (fv_a !== 32'd1) begin errors++; $display("[TB] FAIL perf_flush_a: got %0d expected 1", fv_a); end
    checks++;
    if (sc_b !== 32'd1) begin errors++; $display("[TB] FAIL perf_stall_b: got %0d expected 1", sc_b); end
  endtask
`endif

  initial begin
    set_idle();
    rst_n = 1'b0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_cancel();
    test_mem_wait();
    test_reset_mid();
`ifdef HAZ_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
